// File: rtl/gcd_result_display_if.sv
// Signal bundle between the EC2 processor (master) and the result display stage (slave).
interface gcd_result_display_if;
    logic        Halt;
    logic [7:0]  Output;
    logic [3:0]  state;
    logic [11:0] Bcd;
    logic        Valid;
    logic        Busy;
    logic [6:0]  Seg;
    logic [3:0]  Digit_en;

    modport master (
        output Halt, Output, state,
        input  Bcd, Valid, Busy, Seg, Digit_en
    );

    modport slave (
        input  Halt, Output, state,
        output Bcd, Valid, Busy, Seg, Digit_en
    );
endinterface

// File: rtl/gcd_result_display.sv
// Result display stage: captures the processor result on a Halt rise, converts it
// to 3-digit BCD with a sequential double-dabble (one shift per clock), and drives a
// 4-digit multiplexed active-low 7-segment display (units, tens, hundreds, state).
module gcd_result_display #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    gcd_result_display_if.slave  bus
);

    localparam int unsigned   CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RMAX  = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]    DASH  = 7'b0111111;
    localparam logic [6:0]    BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } fsm_t;

    fsm_t        fsm;
    logic        halt_d;
    logic        halt_rise;
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [19:0] sr_next;
    logic [2:0]  cnt;
    logic [11:0] bcd;
    logic        valid;
    logic        busy;

    logic [CW-1:0] rcnt;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    digit_en;
    logic [6:0]    seg;
    logic [6:0]    seg_next;

    assign halt_rise = bus.Halt & ~halt_d;
    assign idx_next  = idx + 2'd1;

    // Active-low glyph for a hex digit; table is written active-high (gfedcba) and inverted.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one.
    always_comb begin
        sr_adj = sr;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sr_adj[8 + 4*i +: 4] >= 4'd5)
                sr_adj[8 + 4*i +: 4] = sr_adj[8 + 4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[18:0], 1'b0};
    end

    // Capture / convert FSM with registered Bcd, Valid and Busy.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            fsm    <= IDLE;
            halt_d <= 1'b0;
            sr     <= '0;
            cnt    <= '0;
            bcd    <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            halt_d <= bus.Halt;
            case (fsm)
                IDLE, DONE: begin
                    if (halt_rise) begin
                        sr    <= {12'b0, bus.Output};
                        cnt   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                        fsm   <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr  <= sr_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bcd   <= sr_next[19:8];
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        fsm   <= DONE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Glyph for the digit about to be selected, with leading-zero blanking.
    always_comb begin
        seg_next = DASH;
        case (idx_next)
            2'd0: seg_next = valid ? glyph(bcd[3:0]) : DASH;
            2'd1: begin
                if (!valid)
                    seg_next = DASH;
                else if (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)
                    seg_next = BLANK;
                else
                    seg_next = glyph(bcd[7:4]);
            end
            2'd2: begin
                if (!valid)
                    seg_next = DASH;
                else if (bcd[11:8] == 4'd0)
                    seg_next = BLANK;
                else
                    seg_next = glyph(bcd[11:8]);
            end
            default: seg_next = glyph(bus.state);
        endcase
    end

    // Refresh divider and digit scan; Digit_en and Seg change together on the wrap edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rcnt     <= '0;
            idx      <= 2'd0;
            digit_en <= 4'b0001;
            seg      <= DASH;
        end else if (rcnt == RMAX) begin
            rcnt     <= '0;
            idx      <= idx_next;
            digit_en <= 4'b0001 << idx_next;
            seg      <= seg_next;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

    assign bus.Bcd      = bcd;
    assign bus.Valid    = valid;
    assign bus.Busy     = busy;
    assign bus.Seg      = seg;
    assign bus.Digit_en = digit_en;

endmodule

// File: tb/tb_gcd_result_display.sv
// Directed testbench for gcd_result_display.
module tb_gcd_result_display;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    gcd_result_display_if bus ();

    gcd_result_display #(.REFRESH_DIV(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Active-low glyph constants, hand-derived from the segment map a..g = bit0..bit6.
    function automatic logic [6:0] exp_glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic int gcd(input int x, input int y);
        int a, b, t;
        a = x; b = y;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Halt low for one edge then high; returns just after capture edge N.
    task automatic capture(input logic [7:0] v);
        bus.Halt = 1'b0;
        tick();
        bus.Output = v;
        bus.Halt   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.Halt = 1'b0;
        bus.Output = 8'd0;
        bus.state = 4'h5;
        repeat (3) tick();
        Reset = 1'b1;
        checks++;
        if (bus.Bcd !== 12'h000 || bus.Valid !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got Bcd=%h Valid=%b Busy=%b, expected 000 0 0", bus.Bcd, bus.Valid, bus.Busy);
        end
        checks++;
        if (bus.Seg !== 7'b0111111 || bus.Digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL reset_display: got Seg=%b Digit_en=%b, expected 0111111 0001", bus.Seg, bus.Digit_en);
        end
    endtask

    task automatic test_convert_37();
        logic [6:0] exp_seg [4];
        logic [3:0] want;
        capture(8'd37);
        checks++;
        if (bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
            failures++;
            $display("FAIL c37_start: got Busy=%b Valid=%b, expected 1 0", bus.Busy, bus.Valid);
        end
        bus.Output = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                checks++;
                if (bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
                    failures++;
                    $display("FAIL c37_busy step %0d: got Busy=%b Valid=%b, expected 1 0", k, bus.Busy, bus.Valid);
                end
            end
        end
        checks++;
        if (bus.Busy !== 1'b0 || bus.Valid !== 1'b1 || bus.Bcd !== 12'h037) begin
            failures++;
            $display("FAIL c37_done: got Busy=%b Valid=%b Bcd=%h, expected 0 1 037", bus.Busy, bus.Valid, bus.Bcd);
        end
        exp_seg[0] = exp_glyph(7);
        exp_seg[1] = exp_glyph(3);
        exp_seg[2] = 7'h7F;
        exp_seg[3] = exp_glyph(5);
        repeat (17) tick();
        for (int d = 0; d < 4; d++) begin
            want = 4'b0001 << d;
            for (int c = 0; c < 20 && bus.Digit_en !== want; c++) tick();
            checks++;
            if (bus.Digit_en !== want || bus.Seg !== exp_seg[d]) begin
                failures++;
                $display("FAIL c37_digit%0d: got en=%b Seg=%h, expected en=%b Seg=%h", d, bus.Digit_en, bus.Seg, want, exp_seg[d]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [6:0] exp_seg [3];
        logic [3:0] want;
        capture(8'd255);
        repeat (8) tick();
        checks++;
        if (bus.Valid !== 1'b1 || bus.Bcd !== 12'h255) begin
            failures++;
            $display("FAIL bcd255: got Valid=%b Bcd=%h, expected 1 255", bus.Valid, bus.Bcd);
        end
        capture(8'd0);
        repeat (8) tick();
        checks++;
        if (bus.Valid !== 1'b1 || bus.Bcd !== 12'h000) begin
            failures++;
            $display("FAIL bcd0: got Valid=%b Bcd=%h, expected 1 000", bus.Valid, bus.Bcd);
        end
        exp_seg[0] = exp_glyph(0);
        exp_seg[1] = 7'h7F;
        exp_seg[2] = 7'h7F;
        repeat (17) tick();
        for (int d = 0; d < 3; d++) begin
            want = 4'b0001 << d;
            for (int c = 0; c < 20 && bus.Digit_en !== want; c++) tick();
            checks++;
            if (bus.Digit_en !== want || bus.Seg !== exp_seg[d]) begin
                failures++;
                $display("FAIL zero_digit%0d: got en=%b Seg=%h, expected en=%b Seg=%h", d, bus.Digit_en, bus.Seg, want, exp_seg[d]);
            end
        end
    endtask

    task automatic test_ignore_rise();
        capture(8'd100);
        tick();
        bus.Halt = 1'b0;
        tick();
        bus.Halt = 1'b1;
        bus.Output = 8'd9;
        tick();
        tick();
        checks++;
        if (bus.Bcd !== 12'h000 || bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_during_convert: got Bcd=%h Busy=%b, expected 000 1", bus.Bcd, bus.Busy);
        end
        repeat (3) tick();
        checks++;
        if (bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
            failures++;
            $display("FAIL ignore_n7: got Busy=%b Valid=%b, expected 1 0", bus.Busy, bus.Valid);
        end
        tick();
        checks++;
        if (bus.Valid !== 1'b1 || bus.Bcd !== 12'h100) begin
            failures++;
            $display("FAIL ignore_result: got Valid=%b Bcd=%h, expected 1 100", bus.Valid, bus.Bcd);
        end
        repeat (4) tick();
        checks++;
        if (bus.Busy !== 1'b0 || bus.Bcd !== 12'h100) begin
            failures++;
            $display("FAIL no_recapture: got Busy=%b Bcd=%h, expected 0 100", bus.Busy, bus.Bcd);
        end
        capture(8'd9);
        repeat (8) tick();
        checks++;
        if (bus.Valid !== 1'b1 || bus.Bcd !== 12'h009) begin
            failures++;
            $display("FAIL recapture9: got Valid=%b Bcd=%h, expected 1 009", bus.Valid, bus.Bcd);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        capture(8'd200);
        repeat (3) tick();
        Reset = 1'b0;
        bus.Halt = 1'b0;
        tick();
        checks++;
        if (bus.Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Bcd !== 12'h000) begin
            failures++;
            $display("FAIL midreset_regs: got Valid=%b Busy=%b Bcd=%h, expected 0 0 000", bus.Valid, bus.Busy, bus.Bcd);
        end
        checks++;
        if (bus.Seg !== 7'b0111111 || bus.Digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_display: got Seg=%b Digit_en=%b, expected 0111111 0001", bus.Seg, bus.Digit_en);
        end
        Reset = 1'b1;
        bad = 0;
        repeat (12) begin
            tick();
            if (bus.Busy !== 1'b0 || bus.Valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_idle: got %0d cycles active, expected 0", bad);
        end
    endtask

    task automatic test_refresh();
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        int idx;
        bus.state = 4'hA;
        bus.Halt = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        for (int k = 0; k < 32; k++) begin
            idx = (k / 4) % 4;
            exp_en = 4'b0001 << idx;
            exp_seg = (k >= 4 && idx == 3) ? exp_glyph(10) : 7'b0111111;
            checks++;
            if (bus.Digit_en !== exp_en || bus.Seg !== exp_seg) begin
                failures++;
                $display("FAIL refresh k=%0d: got en=%b Seg=%h, expected en=%b Seg=%h", k, bus.Digit_en, bus.Seg, exp_en, exp_seg);
            end
            tick();
        end
    endtask

    task automatic test_gcd();
        int xs [5] = '{48, 126, 121, 127, 100};
        int ys [5] = '{18, 84, 11, 1, 75};
        int g;
        logic [11:0] exp_bcd;
        for (int i = 0; i < 5; i++) begin
            g = gcd(xs[i], ys[i]);
            exp_bcd = {4'(g / 100), 4'((g / 10) % 10), 4'(g % 10)};
            capture(8'(g));
            repeat (8) tick();
            checks++;
            if (bus.Valid !== 1'b1 || bus.Bcd !== exp_bcd) begin
                failures++;
                $display("FAIL gcd(%0d,%0d): got Valid=%b Bcd=%h, expected 1 %h", xs[i], ys[i], bus.Valid, bus.Bcd, exp_bcd);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Reset = 1'b0;
        bus.Halt = 1'b0;
        bus.Output = 8'd0;
        bus.state = 4'h5;
        test_reset();
        test_convert_37();
        test_extremes();
        test_ignore_rise();
        test_reset_mid();
        test_refresh();
        test_gcd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
